values_load: RTL and testbench
==============================

Name: values_load

Overview:
- Operand/opcode capture stage in front of the ALU.
- Samples an 8-bit switch bank into one of three holding registers (operand A, operand B, opcode) when the matching push-button is pressed.
- Outputs drive the ALU inputs directly and hold their value until the next load or reset.

Parameters:
- NB_INPUTS, 8, width of i_switches
- NB_OUTPUTS, 8, width of o_data_a / o_data_b (signed)
- NB_OP, 6, width of o_operation

Ports:
- i_clock  in  1  system clock; all state on rising edge
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- i_buttons  in  3  bit0 = load A, bit1 = load B, bit2 = load operation; asynchronous level inputs
- i_switches  in  NB_INPUTS  signed value to capture
- o_data_a  out  NB_OUTPUTS  signed operand A register
- o_data_b  out  NB_OUTPUTS  signed operand B register
- o_operation  out  NB_OP  opcode register

Behaviour:
- Reset:
  - While i_reset=0, o_data_a, o_data_b, o_operation and all internal sync/edge flops are 0, asynchronously.
  - Release takes effect at the next rising edge.
- Button path, per bit, independent:
  - 2-flop synchronizer (s1, s2) plus history flop s3.
  - Load pulse = s2 & ~s3 (rising edge only).
  - Holding a button produces exactly one load; releasing produces none.
- Latency:
  - Button high at rising edge E0 (captured by s1) → pulse high between E1 and E2 → register updated at E2.
  - The output changes 2 cycles after the sampling edge.
  - Minimum button high time is one clock period, provided it is stable across one rising edge.
- Captured value:
  - The switch value present at the update edge (E2) is used, not the value at button press.
  - o_data_a / o_data_b get i_switches sign-extended if NB_OUTPUTS > NB_INPUTS, or truncated to the low bits if smaller.
  - o_operation gets i_switches[NB_OP-1:0], with zero-extension if NB_OP > NB_INPUTS.
- Simultaneous buttons: every register with an active pulse loads the same switch value in the same cycle. There is no priority.
- No pulse: registers hold their value.
- Reset mid-operation: in-flight pulses are discarded and the synchronizers clear. A button still held at reset release is seen as a new rising edge and loads once, 2 cycles after release.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package values_load_pkg:
  - Button index constants BTN_DATA_A=0, BTN_DATA_B=1, BTN_OPERATION=2.
  - NB_BUTTONS=3.
  - Default widths NB_INPUTS, NB_OUTPUTS, NB_OP.
- Sub-module button_edge_detect:
  - Synchronizer + rising-edge pulse, parameterized by vector width.
  - Same clock and active-low async reset.
  - Instantiated once with width NB_BUTTONS.
- The top level holds the three capture registers and the width-adaptation logic.

Test Plan:
- Reset: i_reset=0 with i_switches=8'hFF and each button pulsed in turn → all outputs stay 0. Deassert → still 0 until a button edge.
- Load A: i_reset=1, i_switches=8'hFF, i_buttons=3'b001 for one cycle → o_data_a=-1 (8'hFF) exactly 2 cycles after the sampling edge. o_data_b=0, o_operation=0.
- Sequential loads:
  - switches 8'h05 + btn0, then 8'hFD + btn1, then 8'b0010_0000 + btn2 (one cycle each, changed back-to-back).
  - Hold each switch value until its load completes.
  - Result: o_data_a=5, o_data_b=-3, o_operation=6'b100000.
- Held button: btn0 held 10 cycles while switches change 8'h11→8'h22 after cycle 4 → o_data_a=8'h11 only; no reload.
- Simultaneous: i_buttons=3'b111, i_switches=8'hC3 → o_data_a=o_data_b=8'hC3, o_operation=6'h03, all in the same cycle.
- Async reset mid-operation: o_data_a=8'h7F, then i_reset dropped between clock edges → o_data_a=0 immediately, before the next edge. A button held through release loads once, 2 cycles after release.

Source files
------------

// File: rtl/values_load_pkg.sv
// Shared constants for the operand/opcode capture stage.
package values_load_pkg;

    // Push-button bit positions within i_buttons
    localparam int unsigned BTN_DATA_A    = 0;
    localparam int unsigned BTN_DATA_B    = 1;
    localparam int unsigned BTN_OPERATION = 2;
    localparam int unsigned NB_BUTTONS    = 3;

    // Default data-path widths
    localparam int unsigned NB_INPUTS  = 8;
    localparam int unsigned NB_OUTPUTS = 8;
    localparam int unsigned NB_OP      = 6;

endpackage : values_load_pkg

// File: rtl/values_load_button_edge_detect.sv
// Per-bit two-flop synchronizer followed by a history flop; emits a
// one-cycle pulse on each rising edge of an asynchronous level input.
module button_edge_detect #(
    parameter int unsigned NB = 3
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [NB-1:0] i_level,
    output logic [NB-1:0] o_pulse
);

    logic [NB-1:0] s1;
    logic [NB-1:0] s2;
    logic [NB-1:0] s3;

    // Synchronize the raw levels and keep one cycle of history
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= i_level;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Rising edge only: a held button gives one pulse, a release gives none
    always_comb begin
        o_pulse = s2 & ~s3;
    end

endmodule : button_edge_detect

// File: rtl/values_load.sv
// Operand/opcode capture stage in front of the ALU: loads the switch bank
// into operand A, operand B or the opcode register on a button press.
module values_load #(
    parameter int unsigned NB_INPUTS  = values_load_pkg::NB_INPUTS,
    parameter int unsigned NB_OUTPUTS = values_load_pkg::NB_OUTPUTS,
    parameter int unsigned NB_OP      = values_load_pkg::NB_OP
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [2:0]                   i_buttons,
    input  logic [NB_INPUTS-1:0]         i_switches,
    output logic signed [NB_OUTPUTS-1:0] o_data_a,
    output logic signed [NB_OUTPUTS-1:0] o_data_b,
    output logic [NB_OP-1:0]             o_operation
);

    import values_load_pkg::*;

    logic [NB_BUTTONS-1:0]         load;
    logic signed [NB_OUTPUTS-1:0]  data_next;
    logic [NB_OP-1:0]              op_next;

    button_edge_detect #(
        .NB(NB_BUTTONS)
    ) u_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (i_buttons),
        .o_pulse (load)
    );

    generate
        if (NB_OUTPUTS > NB_INPUTS) begin : g_data_sext
            // Widen the operand by replicating the switch sign bit
            always_comb begin
                data_next = {{(NB_OUTPUTS-NB_INPUTS){i_switches[NB_INPUTS-1]}}, i_switches};
            end
        end else begin : g_data_trunc
            // Keep the low operand bits of the switch bank
            always_comb begin
                data_next = i_switches[NB_OUTPUTS-1:0];
            end
        end

        if (NB_OP > NB_INPUTS) begin : g_op_zext
            // Opcode is unsigned: pad the top with zeros
            always_comb begin
                op_next = {{(NB_OP-NB_INPUTS){1'b0}}, i_switches};
            end
        end else begin : g_op_trunc
            // Opcode takes the low switch bits
            always_comb begin
                op_next = i_switches[NB_OP-1:0];
            end
        end
    endgenerate

    // Capture registers: each loads on its own pulse, no priority between them
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_operation <= '0;
        end else begin
            if (load[BTN_DATA_A]) begin
                o_data_a <= data_next;
            end
            if (load[BTN_DATA_B]) begin
                o_data_b <= data_next;
            end
            if (load[BTN_OPERATION]) begin
                o_operation <= op_next;
            end
        end
    end

endmodule : values_load

// File: tb/tb_values_load.sv
// Self-checking bench for values_load: directed table, hand-written
// multi-cycle sequences, and randomized traffic against a history model.
module tb_values_load;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic [7:0] sw;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;

    always #5 clk = ~clk;

    values_load #(
        .NB_INPUTS  (8),
        .NB_OUTPUTS (8),
        .NB_OP      (6)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_buttons   (btn),
        .i_switches  (sw),
        .o_data_a    (a),
        .o_data_b    (b),
        .o_operation (op)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: button samples seen at past rising edges, newest first.
    // A register loads at an edge when its button was seen high two edges
    // earlier and low three edges earlier (nothing seen counts as low).
    logic [7:0] ma, mb;
    logic [5:0] mop;
    logic [2:0] seen[$];

    function automatic logic [2:0] seen_at(input int k);
        if (k < seen.size()) return seen[k];
        return 3'b000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_a"},  {24'd0, a},  {24'd0, ma});
        chk({tag, "_b"},  {24'd0, b},  {24'd0, mb});
        chk({tag, "_op"}, {26'd0, op}, {26'd0, mop});
    endtask

    task automatic chk_const(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic [5:0] eop);
        chk({tag, "_a"},  {24'd0, a},  {24'd0, ea});
        chk({tag, "_b"},  {24'd0, b},  {24'd0, eb});
        chk({tag, "_op"}, {26'd0, op}, {26'd0, eop});
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) begin
            ma = '0;
            mb = '0;
            mop = '0;
            seen.delete();
        end
    endtask

    // One clock: model acts at the rising edge, returns at the falling edge
    task automatic cyc();
        logic [2:0] ld;
        @(posedge clk);
        if (rst) begin
            ld = seen_at(1) & ~seen_at(2);
            if (ld[0]) ma = sw;
            if (ld[1]) mb = sw;
            if (ld[2]) mop = sw[5:0];
            seen.push_front(btn);
            if (seen.size() > 3) void'(seen.pop_back());
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] btn;
        logic [7:0] sw;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [5:0] eop;
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{btn: 3'b001, sw: 8'hFF, ea: 8'hFF, eb: 8'h00, eop: 6'h00};
        vt[1] = '{btn: 3'b001, sw: 8'h05, ea: 8'h05, eb: 8'h00, eop: 6'h00};
        vt[2] = '{btn: 3'b010, sw: 8'hFD, ea: 8'h05, eb: 8'hFD, eop: 6'h00};
        vt[3] = '{btn: 3'b100, sw: 8'h20, ea: 8'h05, eb: 8'hFD, eop: 6'h20};
        vt[4] = '{btn: 3'b111, sw: 8'hC3, ea: 8'hC3, eb: 8'hC3, eop: 6'h03};
        vt[5] = '{btn: 3'b001, sw: 8'h7F, ea: 8'h7F, eb: 8'hC3, eop: 6'h03};

        // Reset held: button presses must not load anything
        btn = 3'b000;
        sw  = 8'hFF;
        set_rst(1'b0);
        @(negedge clk);
        chk_const("rst_init", 8'h00, 8'h00, 6'h00);
        for (int k = 0; k < 3; k++) begin
            btn = 3'(1 << k);
            cyc();
            cyc();
            btn = 3'b000;
            cyc();
            chk_const("rst_btn", 8'h00, 8'h00, 6'h00);
        end
        set_rst(1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_const("rst_release", 8'h00, 8'h00, 6'h00);
        end

        // Directed table: one-cycle press, check latency at E1 and result at E2
        for (int i = 0; i < 6; i++) begin
            btn = vt[i].btn;
            sw  = vt[i].sw;
            cyc();
            btn = 3'b000;
            cyc();
            chk_model("tbl_e1");
            cyc();
            chk_const("tbl_e2", vt[i].ea, vt[i].eb, vt[i].eop);
            chk_model("tbl_model");
        end

        // Held button: one load only, switches changing later are ignored
        btn = 3'b001;
        sw  = 8'h11;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 3) sw = 8'h22;
            chk_model("held");
        end
        btn = 3'b000;
        for (int i = 0; i < 3; i++) cyc();
        chk_const("held_final", 8'h11, 8'hC3, 6'h03);

        // Async reset mid-operation, button held through release
        btn = 3'b001;
        sw  = 8'h7F;
        cyc();
        cyc();
        cyc();
        btn = 3'b000;
        chk("pre_rst_a", {24'd0, a}, 32'h7F);
        #2;
        set_rst(1'b0);
        #1;
        chk_const("async_rst", 8'h00, 8'h00, 6'h00);
        btn = 3'b001;
        sw  = 8'h5A;
        @(negedge clk);
        cyc();
        set_rst(1'b1);
        cyc();
        chk("rel_e0_a", {24'd0, a}, 32'h00);
        cyc();
        chk("rel_e1_a", {24'd0, a}, 32'h00);
        cyc();
        chk("rel_e2_a", {24'd0, a}, 32'h5A);
        sw = 8'h66;
        for (int i = 0; i < 3; i++) cyc();
        chk("rel_hold_a", {24'd0, a}, 32'h5A);
        btn = 3'b000;
        cyc();

        // Randomized traffic with persistent button levels and rare resets
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) btn[k] = ~btn[k];
            end
            sw = 8'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                set_rst(1'b0);
                cyc();
                chk_model("rnd_rst");
                set_rst(1'b1);
            end
            cyc();
            chk_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_values_load
